// File: rtl/dec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dec_ctrl_pkg
//  Purpose  : Shared types and constants for the 2-to-4 decoder scan
//             controller. It holds the FSM state enum, the address width
//             and the scan length. It also provides a modulo-2^ADDR_W
//             increment helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dec_ctrl_pkg;

  localparam int ADDR_W   = 2;
  localparam int SCAN_LEN = 4;

  // S_GAP is reachable only when DEC_SCAN_CTRL_GAP_EN is defined.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  // The natural wrap of the ADDR_W-bit sum gives the modulo-4 step (3 -> 0).
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : dwell_cnt
//  Purpose  : W-bit load/decrement counter. It sets a terminal-count flag
//             when the count is zero, and it holds at zero once there.
//  Ports    : clk      - rising-edge clock
//             rstb     - synchronous active-low reset (clears count)
//             load     - load load_val (has priority over dec)
//             load_val - value to load
//             dec      - decrement by one when not at terminal count
//             tc       - high while count == 0
//  Revision : 1.0 - initial release
// ============================================================================
module dwell_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !tc) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule
`default_nettype wire

// File: rtl/dec_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dec_scan_ctrl
//  Purpose  : Drives the address lines and the enable of a 2-to-4 decoder.
//             The block has two modes. A single-address mode dwells on one
//             address. A scan mode walks four consecutive addresses, modulo
//             4. Each address keeps EN high for DWELL+1 cycles.
//  Config   : DEC_SCAN_CTRL_GAP_EN - when defined, one EN-low GAP cycle is
//             inserted between consecutive scan addresses. The default build
//             has no gap and holds EN high across the whole scan.
//  Ports    : CLK     - rising-edge clock
//             RSTB    - synchronous active-low reset
//             START   - start request, honoured only in IDLE
//             MODE    - 0 single address, 1 four-address scan
//             ADDR_IN - first address (bit 0 -> A0)
//             DWELL   - EN-high cycles per address minus one
//             A0, A1  - registered decoder address
//             EN      - registered decoder enable
//             BUSY    - registered, high in every non-IDLE state
//             DONE    - registered one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module dec_scan_ctrl
  import dec_ctrl_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               CLK,
  input  logic               RSTB,
  input  logic               START,
  input  logic               MODE,
  input  logic [1:0]         ADDR_IN,
  input  logic [DWELL_W-1:0] DWELL,
  output logic               A0,
  output logic               A1,
  output logic               EN,
  output logic               BUSY,
  output logic               DONE
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic [ADDR_W-1:0]   step, step_nxt;     // addresses already completed
  logic                mode_l, mode_nxt;
  logic [DWELL_W-1:0]  dwell_l, dwell_nxt;
  logic                en_q, en_nxt;
  logic                busy_q;
  logic                done_q, done_nxt;
  logic                cnt_load, cnt_dec, cnt_tc;
  logic [DWELL_W-1:0]  cnt_load_val;

  dwell_cnt #(
    .W (DWELL_W)
  ) u_dwell_cnt (
    .clk      (CLK),
    .rstb     (RSTB),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  // State register. Every output comes from a flop, so no input reaches an
  // output combinationally.
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state   <= S_IDLE;
      addr    <= '0;
      step    <= '0;
      mode_l  <= 1'b0;
      dwell_l <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      step    <= step_nxt;
      mode_l  <= mode_nxt;
      dwell_l <= dwell_nxt;
      en_q    <= en_nxt;
      busy_q  <= (state_nxt != S_IDLE);
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    step_nxt     = step;
    mode_nxt     = mode_l;
    dwell_nxt    = dwell_l;
    en_nxt       = 1'b0;
    done_nxt     = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = dwell_l;
    cnt_dec      = 1'b0;

    case (state)
      S_IDLE: begin
        // Operands are latched here only. START seen in any other state has
        // no effect.
        if (START) begin
          state_nxt    = S_ACTIVE;
          addr_nxt     = ADDR_IN;
          mode_nxt     = MODE;
          dwell_nxt    = DWELL;
          step_nxt     = '0;
          en_nxt       = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = DWELL;
        end
      end

      S_ACTIVE: begin
        en_nxt = 1'b1;
        if (!cnt_tc) begin
          cnt_dec = 1'b1;
        end else if (!mode_l || (step == ADDR_W'(SCAN_LEN - 1))) begin
          // The sequence is complete. EN drops and DONE pulses on the same
          // edge. The address holds for the idle period.
          state_nxt = S_IDLE;
          en_nxt    = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          addr_nxt = wrap_inc(addr);
          step_nxt = wrap_inc(step);
`ifdef DEC_SCAN_CTRL_GAP_EN
          state_nxt = S_GAP;
          en_nxt    = 1'b0;
`else
          // With no gap, the address changes together with the reload, so EN
          // stays high without a break.
          cnt_load  = 1'b1;
`endif
        end
      end

`ifdef DEC_SCAN_CTRL_GAP_EN
      S_GAP: begin
        state_nxt = S_ACTIVE;
        en_nxt    = 1'b1;
        cnt_load  = 1'b1;
      end
`endif

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign A0   = addr[0];
  assign A1   = addr[1];
  assign EN   = en_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dec_scan_ctrl
//  Purpose  : Self-checking bench for dec_scan_ctrl. Each operation expands
//             into a per-cycle list of expected {A1,A0,EN,BUSY,DONE} values.
//             The list is built from the address/dwell/gap rules, and the
//             DUT ports are compared against it one cycle at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dec_scan_ctrl;

  localparam int DW = 4;
`ifdef DEC_SCAN_CTRL_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RSTB;
  logic          START;
  logic          MODE;
  logic [1:0]    ADDR_IN;
  logic [DW-1:0] DWELL;
  logic          A0, A1, EN, BUSY, DONE;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] exp_q[$];
  logic [4:0] exp2_q[$];

  dec_scan_ctrl #(
    .DWELL_W (DW)
  ) dut (
    .CLK     (CLK),
    .RSTB    (RSTB),
    .START   (START),
    .MODE    (MODE),
    .ADDR_IN (ADDR_IN),
    .DWELL   (DWELL),
    .A0      (A0),
    .A1      (A1),
    .EN      (EN),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] outv();
    return {A1, A0, EN, BUSY, DONE};
  endfunction

  // The expected trace begins in the first cycle after the START edge.
  // Each address contributes DWELL+1 cycles of EN=1. In a gap build, each
  // later address is preceded by one EN=0/BUSY=1 cycle that already shows
  // the new address. The trace ends with one DONE cycle on the last address.
  task automatic build_expected(input bit m, input logic [1:0] a, input int dw,
                                output logic [4:0] q[$]);
    int n = m ? 4 : 1;
    logic [1:0] cur;
    q = {};
    cur = a;
    for (int i = 0; i < n; i++) begin
      cur = 2'((int'(a) + i) % 4);
      if (i > 0 && GAP) q.push_back({cur, 3'b010});
      for (int c = 0; c <= dw; c++) q.push_back({cur, 3'b110});
    end
    q.push_back({cur, 3'b001});
  endtask

  task automatic scramble();
    MODE    = 1'($urandom);
    ADDR_IN = 2'($urandom);
    DWELL   = DW'($urandom);
  endtask

  task automatic launch(input bit m, input logic [1:0] a, input logic [DW-1:0] d);
    START = 1'b1; MODE = m; ADDR_IN = a; DWELL = d;
    @(posedge CLK); #1;
    START = 1'b0;
    scramble();
  endtask

  task automatic test_reset();
    RSTB = 1'b0; START = 1'b1; MODE = 1'b1; ADDR_IN = 2'd3; DWELL = 4'd5;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if (outv() !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset: got=%b want=%b", outv(), 5'b00000);
    end
    START = 1'b0; RSTB = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if (outv() !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_idle: got=%b want=%b", outv(), 5'b00000);
    end
  endtask

  task automatic test_single();
    build_expected(1'b0, 2'd2, 3, exp_q);
    launch(1'b0, 2'd2, 4'd3);
    foreach (exp_q[i]) begin
      n_checks++;
      if (outv() !== exp_q[i]) begin
        n_fail++;
        $display("FAIL single[%0d]: got=%b want=%b", i, outv(), exp_q[i]);
      end
      @(posedge CLK); #1;
    end
    n_checks++;
    if (outv() !== 5'b10000) begin
      n_fail++;
      $display("FAIL single_idle_hold: got=%b want=%b", outv(), 5'b10000);
    end
  endtask

  task automatic test_scan_wrap();
    build_expected(1'b1, 2'd3, 0, exp_q);
    launch(1'b1, 2'd3, 4'd0);
    foreach (exp_q[i]) begin
      n_checks++;
      if (outv() !== exp_q[i]) begin
        n_fail++;
        $display("FAIL scan_wrap[%0d]: got=%b want=%b", i, outv(), exp_q[i]);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_scan_dwell1();
    build_expected(1'b1, 2'd0, 1, exp_q);
    launch(1'b1, 2'd0, 4'd1);
    foreach (exp_q[i]) begin
      n_checks++;
      if (outv() !== exp_q[i]) begin
        n_fail++;
        $display("FAIL scan_dwell1[%0d]: got=%b want=%b", i, outv(), exp_q[i]);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_start_while_busy();
    bit m;
    int d;
    m = 1'($urandom);
    d = $urandom_range(0, 3);
    build_expected(m, 2'd2, d, exp_q);
    launch(m, 2'd2, DW'(d));
    ADDR_IN = 2'd1;
    foreach (exp_q[i]) begin
      n_checks++;
      if (outv() !== exp_q[i]) begin
        n_fail++;
        $display("FAIL busy_start[%0d]: got=%b want=%b", i, outv(), exp_q[i]);
      end
      // START is offered only in cycles where the block is busy.
      START = exp_q[i][1] ? 1'($urandom) : 1'b0;
      @(posedge CLK); #1;
    end
    START = 1'b0;
    n_checks++;
    if (outv() !== {exp_q[exp_q.size()-1][4:3], 3'b000}) begin
      n_fail++;
      $display("FAIL busy_start_no_restart: got=%b want=%b", outv(),
               {exp_q[exp_q.size()-1][4:3], 3'b000});
    end
  endtask

  task automatic test_reset_mid();
    int stop_at;
    build_expected(1'b1, 2'd1, 2, exp_q);
    stop_at = 3 + (GAP ? 1 : 0);  // first cycle of the second address
    launch(1'b1, 2'd1, 4'd2);
    for (int i = 0; i <= stop_at; i++) begin
      n_checks++;
      if (outv() !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_mid_pre[%0d]: got=%b want=%b", i, outv(), exp_q[i]);
      end
      if (i != stop_at) begin
        @(posedge CLK); #1;
      end
    end
    RSTB = 1'b0;
    @(posedge CLK); #1;
    RSTB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (outv() !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset_mid_post[%0d]: got=%b want=%b", i, outv(), 5'b00000);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_dwell_max();
    int en_cycles = 0;
    build_expected(1'b0, 2'd1, (1 << DW) - 1, exp_q);
    launch(1'b0, 2'd1, '1);
    foreach (exp_q[i]) begin
      n_checks++;
      if (outv() !== exp_q[i]) begin
        n_fail++;
        $display("FAIL dwell_max[%0d]: got=%b want=%b", i, outv(), exp_q[i]);
      end
      if (EN) en_cycles++;
      @(posedge CLK); #1;
    end
    n_checks++;
    if (en_cycles !== 16) begin
      n_fail++;
      $display("FAIL dwell_max_count: got=%0d want=%0d", en_cycles, 16);
    end
  endtask

  task automatic test_back_to_back();
    bit m2;
    logic [1:0] a2;
    int d2;
    m2 = 1'($urandom);
    a2 = 2'($urandom);
    d2 = $urandom_range(0, 2);
    build_expected(1'b0, 2'd3, 1, exp_q);
    build_expected(m2, a2, d2, exp2_q);
    launch(1'b0, 2'd3, 4'd1);
    foreach (exp_q[i]) begin
      n_checks++;
      if (outv() !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_first[%0d]: got=%b want=%b", i, outv(), exp_q[i]);
      end
      if (i == exp_q.size() - 1) begin
        // A START issued in the DONE cycle must be accepted.
        START = 1'b1; MODE = m2; ADDR_IN = a2; DWELL = DW'(d2);
      end
      @(posedge CLK); #1;
    end
    START = 1'b0;
    scramble();
    foreach (exp2_q[i]) begin
      n_checks++;
      if (outv() !== exp2_q[i]) begin
        n_fail++;
        $display("FAIL b2b_second[%0d]: got=%b want=%b", i, outv(), exp2_q[i]);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_random();
    bit m;
    logic [1:0] a;
    int d;
    for (int t = 0; t < 20; t++) begin
      m = 1'($urandom);
      a = 2'($urandom);
      d = $urandom_range(0, (1 << DW) - 1);
      build_expected(m, a, d, exp_q);
      launch(m, a, DW'(d));
      foreach (exp_q[i]) begin
        n_checks++;
        if (outv() !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random[%0d][%0d]: got=%b want=%b", t, i, outv(), exp_q[i]);
        end
        @(posedge CLK); #1;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK); #1;
      end
      n_checks++;
      if (outv() !== {exp_q[exp_q.size()-1][4:3], 3'b000}) begin
        n_fail++;
        $display("FAIL random_idle[%0d]: got=%b want=%b", t, outv(),
                 {exp_q[exp_q.size()-1][4:3], 3'b000});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_scan_wrap();
    test_scan_dwell1();
    test_start_while_busy();
    test_reset_mid();
    test_dwell_max();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
